// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch producer feeding the IF/ID pipeline latch.
// Owns the PC, issues instruction-memory reads and queues fetched words in a
// 2-entry FIFO whose head is offered to IF/ID with a valid/ready handshake.
// Redirects flush the FIFO and reload the PC; a HALT word stops fetching.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   imemREN, imemaddr   instruction read request (address is always the PC)
//   ihit, imemload      same-cycle read response
//   out_valid/ready     FIFO head handshake towards IF/ID
//   out_instr/pc/npc    FIFO head contents (zero when empty)
//   redirect(_pc)       flush and restart fetch at a new PC
//   fetch_halted        a HALT word has been fetched, fetch stopped
module fetch_unit #(
  parameter logic [31:0] PC_INIT   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_halted
);

  localparam logic [0:0] StFetch  = 1'b0;
  localparam logic [0:0] StHalted = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] epc_q   [DEPTH];
  logic [31:0] enpc_q  [DEPTH];

  logic full, push, pop, is_halt;

  always_comb begin
    full      = (count_q == 2'(DEPTH));
    // At full, a same-cycle pop frees the slot the new word will occupy.
    imemREN   = !RST && (state_q == StFetch) && !redirect && (!full || out_ready);
    imemaddr  = pc_q;
    out_valid = !RST && (count_q != 2'd0);
    push      = imemREN && ihit;
    pop       = out_valid && out_ready;
    is_halt   = (imemload == HALT_WORD);

    if (count_q != 2'd0) begin
      out_instr = instr_q[rd_ptr_q];
      out_pc    = epc_q[rd_ptr_q];
      out_npc   = enpc_q[rd_ptr_q];
    end else begin
      out_instr = 32'h0;
      out_pc    = 32'h0;
      out_npc   = 32'h0;
    end
    fetch_halted = halted_q;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      // Any hit or pop this cycle belongs to the squashed path.
      state_d  = StFetch;
      pc_d     = redirect_pc;
      halted_d = 1'b0;
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
        if (is_halt) begin
          state_d  = StHalted;
          halted_d = 1'b1;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StFetch;
      pc_q     <= PC_INIT;
      halted_q <= 1'b0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        instr_q[i] <= 32'h0;
        epc_q[i]   <= 32'h0;
        enpc_q[i]  <= 32'h0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      // push is already false during a redirect (imemREN is gated).
      if (push) begin
        instr_q[wr_ptr_q] <= imemload;
        epc_q[wr_ptr_q]   <= pc_q;
        enpc_q[wr_ptr_q]  <= pc_q + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] PcInit = 32'h0000_0000;
  localparam logic [31:0] Halt   = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit = 1'b0;
  logic [31:0] imemload = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_npc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_halted;

  fetch_unit #(
    .PC_INIT  (PcInit),
    .HALT_WORD(Halt),
    .DEPTH    (2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .ihit        (ihit),
    .imemload    (imemload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_npc     (out_npc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_halted(fetch_halted)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } ent_t;

  // Reference model: the FIFO is a plain queue, fetch state is pc + halted flag.
  ent_t        exp_q[$];
  logic [31:0] m_pc     = PcInit;
  logic        m_halted = 1'b0;
  logic        primed   = 1'b0;
  int          errors   = 0;
  int          checks   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check request side at +1, update model at +3.
  // The monitor runs at +2, between the request check and the model update.
  task automatic cycle(input logic r, input logic h, input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic [31:0] ld);
    logic exp_ren;
    @(negedge CLK);
    RST = r; ihit = h; out_ready = rdy; redirect = rd; redirect_pc = rpc; imemload = ld;
    #1;
    exp_ren = !r && !m_halted && !rd && (exp_q.size() < 2 || rdy);
    if (primed) begin
      chk("imemREN", 32'(imemREN), 32'(exp_ren));
      chk("imemaddr", imemaddr, m_pc);
      chk("fetch_halted", 32'(fetch_halted), 32'(m_halted));
    end
    #2;
    if (r) begin
      exp_q.delete();
      m_pc = PcInit;
      m_halted = 1'b0;
      primed = 1'b1;
    end else if (rd) begin
      exp_q.delete();
      m_pc = rpc;
      m_halted = 1'b0;
    end else if (exp_ren && h) begin
      exp_q.push_back('{instr: ld, pc: m_pc, npc: m_pc + 32'd4});
      if (ld == Halt) m_halted = 1'b1;
      else m_pc = m_pc + 32'd4;
    end
  endtask

  // Monitor: compares the presented head against the scoreboard, pops on handshake.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (primed) begin
        chk("out_valid", 32'(out_valid), 32'(!RST && exp_q.size() != 0));
        if (!RST) begin
          if (exp_q.size() != 0) begin
            chk("out_instr", out_instr, exp_q[0].instr);
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_npc", out_npc, exp_q[0].npc);
            if (out_ready) void'(exp_q.pop_front());
          end else begin
            chk("empty_instr", out_instr, 32'h0);
            chk("empty_pc", out_pc, 32'h0);
            chk("empty_npc", out_npc, 32'h0);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc, ld;
    // Reset.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Streaming with ready high: no bubbles.
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0, 32'h2001_0004 + 32'h0001_0004 * i);
    // Fill to two entries while stalled, then drain and resume.
    cycle(0, 0, 1, 1, 32'h0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, 32'h1000_0000 + i);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 32'h1100_0000 + i);
    // Misses at 0x10 then a hit.
    cycle(0, 0, 1, 1, 32'h10, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 32'hDEAD_0000);
    cycle(0, 1, 1, 0, 0, 32'h1234_5678);
    // Full FIFO, redirect with an ignored hit.
    cycle(0, 1, 0, 0, 0, 32'hAAAA_0001);
    cycle(0, 1, 0, 0, 0, 32'hAAAA_0002);
    cycle(0, 1, 0, 1, 32'h40, 32'hBBBB_0000);
    cycle(0, 0, 0, 0, 0, 0);
    // HALT at 0x0C, drain while halted, redirect back to 0x08.
    cycle(0, 0, 0, 1, 32'h0C, 0);
    cycle(0, 1, 0, 0, 0, Halt);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 32'h5555_0000);
    cycle(0, 1, 1, 1, 32'h08, 32'h6666_0000);
    cycle(0, 1, 1, 0, 0, 32'h7777_0000);
    // PC wrap.
    cycle(0, 0, 1, 1, 32'hFFFF_FFF8, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0, 32'h0ABC_0000 + i);
    // Reset while full with a miss pending.
    cycle(0, 1, 0, 0, 0, 32'h0101_0101);
    cycle(0, 1, 0, 0, 0, 32'h0202_0202);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 32'hFFFF_FFF8;
        1:       rpc = $urandom;
        default: rpc = $urandom & 32'h0000_0FFC;
      endcase
      ld = ($urandom_range(0, 15) == 0) ? Halt : $urandom;
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rpc, ld);
    end
    cycle(0, 0, 1, 0, 0, 0);
    @(negedge CLK);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
